// File: rtl/pipe_mem_ctrl_pkg.sv
// Shared definitions for the pipeline SRAM controller: FSM state codes,
// stall-vector bit positions and the stall patterns driven to the pipeline.
package pipe_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [5:0] STALL_NONE     = 6'b000000;
  localparam logic [5:0] STALL_FETCH    = 6'b000011;
  localparam logic [5:0] STALL_LOAD_USE = 6'b000111;
  localparam logic [5:0] STALL_MEM_ACC  = 6'b011111;

  localparam logic RST_ENABLE = 1'b0;

endpackage

// File: rtl/pipe_mem_ctrl.sv
// Pipeline controller for the shared single-port SRAM: arbitrates fetch vs
// data access, sequences wait states and drives the stall vector / flush.
module pipe_mem_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              load_use,
  input  logic              branch_flush,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic [5:0]        stall,
  output logic              flush
);
  import pipe_mem_ctrl_pkg::*;

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              abort_q;
  logic              data_q;
  logic              ram_ce_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] if_inst_q;
  logic              if_valid_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              mem_done_q;
  logic [5:0]        stall_s;
  logic              flush_s;

  // Stall priority: data access, then load-use, then an outstanding fetch.
  always_comb begin
    stall_s = STALL_NONE;
    if (mem_req && !mem_done_q) begin
      stall_s = STALL_MEM_ACC;
    end else if (load_use) begin
      stall_s = STALL_LOAD_USE;
    end else if (if_req && !if_valid_q) begin
      stall_s = STALL_FETCH;
    end else begin
      stall_s = STALL_NONE;
    end
  end

  assign flush_s = branch_flush & ~stall_s[STALL_ID];

  // Access FSM with wait-state counter; every SRAM pin and pulse is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      abort_q     <= 1'b0;
      data_q      <= 1'b0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_inst_q   <= '0;
      if_valid_q  <= 1'b0;
      mem_rdata_q <= '0;
      mem_done_q  <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          abort_q <= 1'b0;
          if (mem_req) begin
            state_q     <= ST_DATA;
            data_q      <= 1'b1;
            cnt_q       <= CNT_LOAD;
            ram_ce_q    <= 1'b1;
            ram_we_q    <= mem_we;
            ram_addr_q  <= mem_addr;
            ram_wdata_q <= mem_wdata;
          end else if (if_req) begin
            state_q    <= ST_FETCH;
            data_q     <= 1'b0;
            cnt_q      <= CNT_LOAD;
            ram_ce_q   <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= if_addr;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_FETCH, ST_DATA: begin
          if (!data_q && flush_s) begin
            abort_q <= 1'b1;
          end
          if (cnt_q == CNT_ZERO) begin
            state_q  <= ST_RESP;
            ram_ce_q <= 1'b0;
            ram_we_q <= 1'b0;
            if (data_q) begin
              mem_done_q <= 1'b1;
              // Stores leave the previous load data untouched.
              if (!ram_we_q) begin
                mem_rdata_q <= ram_rdata;
              end
            end else begin
              if_inst_q  <= ram_rdata;
              if_valid_q <= ~(abort_q | flush_s);
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          abort_q <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          abort_q  <= 1'b0;
          ram_ce_q <= 1'b0;
          ram_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign ram_ce    = ram_ce_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_inst   = if_inst_q;
  assign if_valid  = if_valid_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;
  assign stall     = stall_s;
  assign flush     = flush_s;

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// Directed bench for pipe_mem_ctrl; fetch/load results are scoreboarded and
// matched against the if_valid / mem_done pulses by a monitor.
module tb_pipe_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we, load_use, branch_flush;
  logic [15:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic        ram_ce, ram_we, if_valid, mem_done, flush;
  logic [15:0] ram_addr, ram_wdata, if_inst, mem_rdata;
  logic [5:0]  stall;

  logic        w3_mem_req;
  logic        w3_ram_ce, w3_ram_we, w3_if_valid, w3_mem_done, w3_flush;
  logic [15:0] w3_ram_addr, w3_ram_wdata, w3_if_inst, w3_mem_rdata;
  logic [5:0]  w3_stall;

  logic [15:0] sram [0:255];
  logic [15:0] exp_if [$];
  logic [15:0] exp_mem [$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  assign ram_rdata = sram[ram_addr[7:0]];

  pipe_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .load_use(load_use), .branch_flush(branch_flush), .ram_rdata(ram_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .if_inst(if_inst), .if_valid(if_valid), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall(stall), .flush(flush)
  );

  pipe_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .mem_req(w3_mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .load_use(load_use), .branch_flush(branch_flush), .ram_rdata(16'hBEEF),
    .ram_ce(w3_ram_ce), .ram_we(w3_ram_we), .ram_addr(w3_ram_addr), .ram_wdata(w3_ram_wdata),
    .if_inst(w3_if_inst), .if_valid(w3_if_valid), .mem_rdata(w3_mem_rdata), .mem_done(w3_mem_done),
    .stall(w3_stall), .flush(w3_flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for the WAIT_CYCLES=1 instance.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst) begin
      if (if_valid) begin
        if (exp_if.size() == 0) chk("if_valid_unexpected", 32'(if_valid), 32'd0);
        else begin
          e = exp_if.pop_front();
          chk("if_inst", 32'(if_inst), 32'(e));
        end
      end
      if (mem_done) begin
        if (exp_mem.size() == 0) chk("mem_done_unexpected", 32'(mem_done), 32'd0);
        else begin
          e = exp_mem.pop_front();
          chk("mem_rdata", 32'(mem_rdata), 32'(e));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 16'(i);
    sram[8'h10] = 16'h4A05;
    sram[8'h12] = 16'h7E01;
    sram[8'h14] = 16'h0B0B;
    sram[8'h16] = 16'h0C0C;
    sram[8'h18] = 16'h0D0D;
    sram[8'h00] = 16'h5A5A;
    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; load_use = 1'b0;
    branch_flush = 1'b0; w3_mem_req = 1'b0;
    if_addr = 16'h0000; mem_addr = 16'h0000; mem_wdata = 16'h0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ce", 32'(ram_ce), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_inst", 32'(if_inst), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_rdata", 32'(mem_rdata), 32'd0);
    chk("rst_done", 32'(mem_done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk) rst = 1'b1;

    // 1: plain fetch
    cyc(); if_req = 1'b1; if_addr = 16'h0010; exp_if.push_back(16'h4A05); #1;
    chk("t1_stall_c0", 32'(stall), 32'h03);
    chk("t1_ce_c0", 32'(ram_ce), 32'd0);
    cyc(); #1;
    chk("t1_ce_c1", 32'(ram_ce), 32'd1);
    chk("t1_addr_c1", 32'(ram_addr), 32'h0010);
    chk("t1_stall_c1", 32'(stall), 32'h03);
    cyc(); #1;
    chk("t1_valid_c2", 32'(if_valid), 32'd1);
    chk("t1_inst_c2", 32'(if_inst), 32'h4A05);
    chk("t1_stall_c2", 32'(stall), 32'h00);
    chk("t1_ce_c2", 32'(ram_ce), 32'd0);
    if_req = 1'b0;
    cyc();

    // 2: simultaneous requests, data wins
    cyc(); if_req = 1'b1; if_addr = 16'h0012; mem_req = 1'b1; mem_we = 1'b0;
    mem_addr = 16'h8000; exp_mem.push_back(16'h5A5A); #1;
    chk("t2_stall_c0", 32'(stall), 32'h1F);
    cyc(); #1;
    chk("t2_ce_c1", 32'(ram_ce), 32'd1);
    chk("t2_we_c1", 32'(ram_we), 32'd0);
    chk("t2_addr_c1", 32'(ram_addr), 32'h8000);
    chk("t2_stall_c1", 32'(stall), 32'h1F);
    cyc(); #1;
    chk("t2_done_c2", 32'(mem_done), 32'd1);
    chk("t2_stall_c2", 32'(stall), 32'h03);
    mem_req = 1'b0; exp_if.push_back(16'h7E01);
    cyc(); #1;
    chk("t2_ce_c3", 32'(ram_ce), 32'd0);
    cyc(); #1;
    chk("t2_fetch_addr", 32'(ram_addr), 32'h0012);
    chk("t2_fetch_ce", 32'(ram_ce), 32'd1);
    cyc(); #1;
    chk("t2_fetch_valid", 32'(if_valid), 32'd1);
    if_req = 1'b0;
    cyc();

    // 3: store, no re-store while mem_req lingers
    cyc(); mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h8002; mem_wdata = 16'h1234;
    exp_mem.push_back(16'h5A5A); #1;
    chk("t3_stall_c0", 32'(stall), 32'h1F);
    cyc(); #1;
    chk("t3_we_c1", 32'(ram_we), 32'd1);
    chk("t3_wdata_c1", 32'(ram_wdata), 32'h1234);
    chk("t3_addr_c1", 32'(ram_addr), 32'h8002);
    cyc(); #1;
    chk("t3_we_c2", 32'(ram_we), 32'd0);
    chk("t3_done_c2", 32'(mem_done), 32'd1);
    mem_req = 1'b0; mem_we = 1'b0;
    cyc(); #1;
    chk("t3_ce_c3", 32'(ram_ce), 32'd0);
    cyc(); #1;
    chk("t3_ce_c4", 32'(ram_ce), 32'd0);

    // 4: branch flush during fetch aborts that fetch
    cyc(); if_req = 1'b1; if_addr = 16'h0014;
    cyc(); branch_flush = 1'b1; #1;
    chk("t4_flush", 32'(flush), 32'd1);
    cyc(); branch_flush = 1'b0; #1;
    chk("t4_no_valid", 32'(if_valid), 32'd0);
    if_addr = 16'h0016; exp_if.push_back(16'h0C0C);
    cyc();
    cyc(); #1;
    chk("t4_refetch_addr", 32'(ram_addr), 32'h0016);
    cyc(); #1;
    chk("t4_valid", 32'(if_valid), 32'd1);
    if_req = 1'b0;
    cyc();

    // 5: load-use while fetch pending; pulse under stall is dropped and refetched
    cyc(); if_req = 1'b1; if_addr = 16'h0018; exp_if.push_back(16'h0D0D);
    cyc(); load_use = 1'b1; branch_flush = 1'b1; #1;
    chk("t5_stall_c1", 32'(stall), 32'h07);
    chk("t5_flush_deferred", 32'(flush), 32'd0);
    branch_flush = 1'b0;
    cyc(); #1;
    chk("t5_valid_under_stall", 32'(if_valid), 32'd1);
    chk("t5_stall_c2", 32'(stall), 32'h07);
    load_use = 1'b0; exp_if.push_back(16'h0D0D);
    cyc();
    cyc(); #1;
    chk("t5_refetch_addr", 32'(ram_addr), 32'h0018);
    cyc(); #1;
    chk("t5_refetch_valid", 32'(if_valid), 32'd1);
    if_req = 1'b0;
    cyc();

    // 6: reset mid-access with WAIT_CYCLES=3
    cyc(); w3_mem_req = 1'b1; mem_addr = 16'h8000;
    cyc(); #1;
    chk("t6_ce_c1", 32'(w3_ram_ce), 32'd1);
    cyc(); #1;
    chk("t6_ce_c2", 32'(w3_ram_ce), 32'd1);
    rst = 1'b0; w3_mem_req = 1'b0; #1;
    chk("t6_ce_async", 32'(w3_ram_ce), 32'd0);
    @(negedge clk) rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk("t6_no_done", 32'(w3_mem_done), 32'd0);
      chk("t6_idle_ce", 32'(w3_ram_ce), 32'd0);
    end
    cyc(); w3_mem_req = 1'b1;
    cyc(); #1;
    chk("t6_new_ce_c1", 32'(w3_ram_ce), 32'd1);
    cyc(); cyc(); #1;
    chk("t6_new_ce_c3", 32'(w3_ram_ce), 32'd1);
    chk("t6_new_done_c3", 32'(w3_mem_done), 32'd0);
    cyc(); #1;
    chk("t6_new_done_c4", 32'(w3_mem_done), 32'd1);
    chk("t6_new_rdata", 32'(w3_mem_rdata), 32'hBEEF);
    w3_mem_req = 1'b0;
    repeat (3) cyc();

    chk("sb_if_empty", 32'(exp_if.size()), 32'd0);
    chk("sb_mem_empty", 32'(exp_mem.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
